instruction_memory_responder: RTL and testbench

- Memory-side responder for the core's instruction fetch interface. The fetch unit is the initiator; this block serves its requests.
- Holds a word-addressed instruction store that a program loader port can write.
- Accepts one fetch request at a time over a valid/ready handshake. Inserts a configurable number of wait states, then returns the instruction word (or an error) over a valid/ready response channel.

---
 rtl/instruction_memory_responder.sv | 148 ++++++++++++++
 tb/tb_instruction_memory_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_responder.sv
// Memory-side responder for the instruction fetch port: a loadable word store
// served one request at a time with a fixed number of wait states.
module instruction_memory_responder #(
  parameter logic [31:0] BASE_ADDRESS      = 32'h0000_0000,
  parameter int          DEPTH_WORDS       = 1024,
  parameter int          WAIT_STATES       = 1,
  parameter logic [31:0] ERROR_INSTRUCTION = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_address,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instruction,
  output logic        resp_error,
  input  logic        load_enable,
  input  logic [31:0] load_index,
  input  logic [31:0] load_data,
  output logic        busy
);

  localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_STATES);
  localparam bit          WAIT_ZERO   = (WAIT_STATES == 0);
  localparam bit          WAIT_CFG_OK = (WAIT_STATES >= 0) && (WAIT_STATES <= 15);
  localparam logic [31:0] DEPTH_W32   = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              resp_load;
  logic [3:0]        wait_count;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;

  logic [31:0]       offset;
  logic [31:0]       word_offset;
  logic              req_err;
  logic [IDX_W-1:0]  req_idx;
  logic              sel_err;
  logic [IDX_W-1:0]  sel_idx;

  logic [31:0]       store [DEPTH_WORDS];

  // Addresses below BASE_ADDRESS wrap to a huge unsigned offset and land in the error range.
  always_comb begin
    offset      = req_address - BASE_ADDRESS;
    word_offset = offset >> 2;
    req_err     = (req_address[1:0] != 2'b00) || (word_offset >= DEPTH_W32);
    req_idx     = word_offset[IDX_W-1:0];
  end

  // NOTE: the store is intentionally left without a reset; its contents
  // survive reset and the loader keeps writing while reset is asserted.
  always_ff @(posedge CLK) begin
    if (load_enable && (load_index < DEPTH_W32)) begin
      store[load_index[IDX_W-1:0]] <= load_data;
    end
  end

  always_ff @(posedge CLK) begin
    cfg_check: assert (WAIT_CFG_OK)
      else $error("instruction_memory_responder: WAIT_STATES=%0d outside 0..15", WAIT_STATES);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    resp_load  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_ZERO) begin
            resp_load  = 1'b1;
            next_state = ST_RESP;
          end else begin
            next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_count <= 4'd1) begin
          resp_load  = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);

  // With zero wait states the response loads on the accepting edge, straight from the live request.
  assign sel_err = accept ? req_err : err_q;
  assign sel_idx = accept ? req_idx : idx_q;

  // The store read shares the edge with any load write, so a same-edge write returns old data.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wait_count       <= 4'd0;
      err_q            <= 1'b0;
      idx_q            <= '0;
      resp_instruction <= 32'h0;
      resp_error       <= 1'b0;
    end else begin
      if (accept) begin
        err_q      <= req_err;
        idx_q      <= req_idx;
        wait_count <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (wait_count != 4'd0)) begin
        wait_count <= wait_count - 4'd1;
      end
      if (resp_load) begin
        resp_error       <= sel_err;
        resp_instruction <= sel_err ? ERROR_INSTRUCTION : store[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Bench for instruction_memory_responder: five instances with different wait
// states / base addresses, directed cases plus random fetches against a model.
module tb_instruction_memory_responder;

  localparam int NDUT = 5;
  // Wait states per instance, instance 0 in the low nibble: 1, 0, 3, 2, 1.
  localparam logic [4*NDUT-1:0] WS_VEC = {4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
  localparam int DEPTH = 1024;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req_valid        [NDUT];
  logic        req_ready        [NDUT];
  logic [31:0] req_address      [NDUT];
  logic        resp_valid       [NDUT];
  logic        resp_ready       [NDUT];
  logic [31:0] resp_instruction [NDUT];
  logic        resp_error       [NDUT];
  logic        load_enable      [NDUT];
  logic [31:0] load_index       [NDUT];
  logic [31:0] load_data        [NDUT];
  logic        busy             [NDUT];

  logic [31:0] mm [NDUT][DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    instruction_memory_responder #(
      .BASE_ADDRESS     ((g == 4) ? 32'h0000_0100 : 32'h0000_0000),
      .DEPTH_WORDS      (DEPTH),
      .WAIT_STATES      (int'(WS_VEC[g*4 +: 4])),
      .ERROR_INSTRUCTION(32'h0000_0013)
    ) u_dut (
      .CLK             (CLK),
      .reset           (reset),
      .req_valid       (req_valid[g]),
      .req_ready       (req_ready[g]),
      .req_address     (req_address[g]),
      .resp_valid      (resp_valid[g]),
      .resp_ready      (resp_ready[g]),
      .resp_instruction(resp_instruction[g]),
      .resp_error      (resp_error[g]),
      .load_enable     (load_enable[g]),
      .load_index      (load_index[g]),
      .load_data       (load_data[g]),
      .busy            (busy[g])
    );
  end

  function automatic int ws_of(int d);
    return int'(WS_VEC[d*4 +: 4]);
  endfunction

  function automatic logic [31:0] base_of(int d);
    return (d == 4) ? 32'h0000_0100 : 32'h0000_0000;
  endfunction

  // Reference: {error, instruction} for a byte address, straight from the address rules.
  function automatic logic [32:0] ref_fetch(int d, logic [31:0] a);
    logic [31:0] off;
    off = a - base_of(d);
    if ((a % 4) != 0 || (off / 4) >= DEPTH) return {1'b1, 32'h0000_0013};
    return {1'b0, mm[d][off / 4]};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic load_one(int d, logic [31:0] idx, logic [31:0] data);
    load_enable[d] = 1'b1;
    load_index[d]  = idx;
    load_data[d]   = data;
    if (idx < DEPTH) mm[d][idx] = data;
    @(negedge CLK);
    load_enable[d] = 1'b0;
  endtask

  task automatic accept_req(int d, logic [31:0] a);
    check($sformatf("d%0d_req_ready_idle", d), req_ready[d], 1);
    req_valid[d]   = 1'b1;
    req_address[d] = a;
    @(negedge CLK);
    req_valid[d]   = 1'b0;
    req_address[d] = $urandom;
  endtask

  // Bounded wait for resp_valid; lat0 is the cycle number (after acceptance) on entry.
  task automatic wait_resp(int d, int lat0);
    int lat;
    lat = lat0;
    while (!resp_valid[d] && lat < 40) begin
      check($sformatf("d%0d_busy_wait", d), busy[d], 1);
      check($sformatf("d%0d_req_ready_wait", d), req_ready[d], 0);
      @(negedge CLK);
      lat++;
    end
    check($sformatf("d%0d_resp_latency", d), lat, ws_of(d) + 1);
  endtask

  task automatic finish_resp(int d, logic [31:0] exp_i, logic exp_e, int bp);
    check($sformatf("d%0d_resp_valid", d), resp_valid[d], 1);
    check($sformatf("d%0d_resp_instr", d), resp_instruction[d], exp_i);
    check($sformatf("d%0d_resp_error", d), resp_error[d], exp_e);
    check($sformatf("d%0d_busy_resp", d), busy[d], 1);
    check($sformatf("d%0d_req_ready_resp", d), req_ready[d], 0);
    for (int i = 0; i < bp; i++) begin
      resp_ready[d] = 1'b0;
      @(negedge CLK);
      check($sformatf("d%0d_bp_valid", d), resp_valid[d], 1);
      check($sformatf("d%0d_bp_instr", d), resp_instruction[d], exp_i);
      check($sformatf("d%0d_bp_error", d), resp_error[d], exp_e);
      check($sformatf("d%0d_bp_req_ready", d), req_ready[d], 0);
    end
    resp_ready[d] = 1'b1;
    @(negedge CLK);
    resp_ready[d] = 1'b0;
    check($sformatf("d%0d_done_valid", d), resp_valid[d], 0);
    check($sformatf("d%0d_done_req_ready", d), req_ready[d], 1);
    check($sformatf("d%0d_done_busy", d), busy[d], 0);
  endtask

  task automatic fetch(int d, logic [31:0] a, int bp);
    logic [32:0] exp;
    exp = ref_fetch(d, a);
    accept_req(d, a);
    wait_resp(d, 1);
    finish_resp(d, exp[31:0], exp[32], bp);
  endtask

  // Load to index 5 of instance 3 on the response-load edge (same_edge) or one edge earlier.
  task automatic collision(bit same_edge, logic [31:0] exp_i);
    accept_req(3, 32'h14);
    if (same_edge) @(negedge CLK);
    load_one(3, 32'd5, 32'h2222_2222);
    wait_resp(3, same_edge ? 3 : 2);
    finish_resp(3, exp_i, 1'b0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int d;
    int kind;
    reset = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      req_valid[i]   = 1'b0;
      req_address[i] = 32'h0;
      resp_ready[i]  = 1'b0;
      load_enable[i] = 1'b0;
      load_index[i]  = 32'h0;
      load_data[i]   = 32'h0;
    end
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("d%0d_rst_req_ready", i), req_ready[i], 1);
      check($sformatf("d%0d_rst_resp_valid", i), resp_valid[i], 0);
      check($sformatf("d%0d_rst_resp_instr", i), resp_instruction[i], 0);
      check($sformatf("d%0d_rst_resp_error", i), resp_error[i], 0);
      check($sformatf("d%0d_rst_busy", i), busy[i], 0);
    end

    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < NDUT; k++) begin
        load_enable[k] = 1'b1;
        load_index[k]  = i;
        load_data[k]   = $urandom;
        mm[k][i]       = load_data[k];
      end
      @(negedge CLK);
    end
    for (int k = 0; k < NDUT; k++) load_enable[k] = 1'b0;

    load_one(0, 32'd0, 32'h0050_0093);
    load_one(1, 32'd1, 32'h00a0_0113);
    load_one(3, 32'd5, 32'h1111_1111);
    load_one(0, 32'd1024, 32'hDEAD_BEEF);
    load_one(0, 32'h8000_0000, 32'hBAD0_BAD0);

    fetch(0, 32'h0, 0);
    fetch(1, 32'h4, 0);
    fetch(1, 32'h0, 0);
    fetch(0, 32'h8, 3);
    fetch(0, 32'h6, 1);
    fetch(0, 32'h1000, 0);
    fetch(0, 32'hFFC, 0);
    fetch(0, 32'hFFFF_FFFC, 0);
    fetch(4, 32'hFC, 0);
    fetch(4, 32'h100, 0);
    fetch(4, 32'h10FC, 0);
    fetch(4, 32'h1100, 0);
    fetch(2, 32'h40, 1);

    // Reset while instance 2 waits; instance 0 loads during the reset edge.
    accept_req(2, 32'h20);
    check("d2_busy_before_reset", busy[2], 1);
    reset = 1'b1;
    load_enable[0] = 1'b1;
    load_index[0]  = 32'd7;
    load_data[0]   = $urandom;
    mm[0][7]       = load_data[0];
    @(negedge CLK);
    reset = 1'b0;
    load_enable[0] = 1'b0;
    check("d2_rst_wait_valid", resp_valid[2], 0);
    check("d2_rst_wait_req_ready", req_ready[2], 1);
    check("d2_rst_wait_busy", busy[2], 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("d2_no_resp_after_reset", resp_valid[2], 0);
    end
    fetch(0, 32'h1C, 0);
    fetch(2, 32'h20, 0);

    collision(1'b1, 32'h1111_1111);
    load_one(3, 32'd5, 32'h1111_1111);
    collision(1'b0, 32'h2222_2222);

    for (int n = 0; n < 60; n++) begin
      d    = $urandom_range(0, NDUT - 1);
      kind = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) load_one(d, $urandom_range(0, 1100), $urandom);
      case (kind)
        0, 1: a = base_of(d) + 4 * $urandom_range(0, DEPTH - 1);
        2:    a = base_of(d) + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
        3:    a = (d == 4) ? 4 * $urandom_range(0, 63) : 32'h1000 + 4 * $urandom_range(0, 100000);
        default: a = $urandom;
      endcase
      fetch(d, a, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
